// File: rtl/mips_mode_sequencer_pkg.sv
// Shared definitions for the switch-driven processor control sequencer:
// state encoding, clear-sweep phases, ALU op codes, switch mode codes,
// instruction field positions and the error display constant.
package mips_mode_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SAVE_A,
    ST_SAVE_D,
    ST_READ_A,
    ST_READ_S,
    ST_OP_W1,
    ST_OP_W2,
    ST_OP_ARM,
    ST_FETCH_A,
    ST_FETCH_B,
    ST_EXEC,
    ST_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    CLR_SWEEP,
    CLR_SHOW,
    CLR_HOLD
  } clr_phase_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_t;

  // Switch values recognised in IDLE
  localparam int MODE_SAVE = 2;
  localparam int MODE_READ = 3;
  localparam int MODE_OP   = 4;

  // Instruction word 1: sr1[9:6] sr2[5:2] op[1:0]
  localparam int F_SR1_LSB = 6;
  localparam int F_SR2_LSB = 2;
  localparam int F_OP_LSB  = 0;
  // Instruction word 2: imm[5] dr[4:1] out[0]
  localparam int F_IMM_BIT = 5;
  localparam int F_DR_LSB  = 1;
  localparam int F_OUT_BIT = 0;

  localparam logic [15:0] ERR_DISP = 16'hFFFF;

  // One-hot mode indication: [0]IDLE [1]SAVE [2]READ [3]OP-IN [4]EXEC [5]CLEAR
  function automatic logic [5:0] mode_leds(input state_t s);
    mode_leds = 6'b000000;
    case (s)
      ST_IDLE:                         mode_leds = 6'b000001;
      ST_SAVE_A, ST_SAVE_D:            mode_leds = 6'b000010;
      ST_READ_A, ST_READ_S:            mode_leds = 6'b000100;
      ST_OP_W1, ST_OP_W2, ST_OP_ARM:   mode_leds = 6'b001000;
      ST_FETCH_A, ST_FETCH_B, ST_EXEC: mode_leds = 6'b010000;
      ST_CLEAR:                        mode_leds = 6'b100000;
      default:                         mode_leds = 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/mips_mode_sequencer_if.sv
// Register-file, ALU and display bus between the sequencer (master)
// and the datapath blocks it drives (slave).
interface mips_mode_sequencer_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          alu_start;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_done;
  logic [DW-1:0] alu_result;
  logic          alu_err;
  logic          disp_load;
  logic [DW-1:0] disp_value;

  modport master (
    output mem_addr, mem_we, mem_wdata, alu_start, alu_op, alu_a, alu_b,
           disp_load, disp_value,
    input  mem_rdata, alu_done, alu_result, alu_err
  );

  modport slave (
    input  mem_addr, mem_we, mem_wdata, alu_start, alu_op, alu_a, alu_b,
           disp_load, disp_value,
    output mem_rdata, alu_done, alu_result, alu_err
  );
endinterface

// File: rtl/mips_mode_sequencer_enter_pulse_sync.sv
// SYNC-flop synchronizer for an asynchronous board input, plus a one-cycle
// falling-edge pulse that appears SYNC+1 clocks after the input falls.
// SYNC must be at least 2.
module mips_mode_sequencer_enter_pulse_sync #(
  parameter int   SYNC    = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  logic [SYNC-1:0] sync_q;
  logic            last_q;

  // Synchronizer chain, delayed copy of its output and registered fall pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC{RST_VAL}};
      last_q <= RST_VAL;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], din};
      last_q <= sync_q[SYNC-1];
      fall   <= last_q & ~sync_q[SYNC-1];
    end
  end

  assign level = sync_q[SYNC-1];

endmodule

// File: rtl/mips_mode_sequencer.sv
// Top-level control FSM of the switch-driven processor: turns enter presses
// and the switch bank into register-file reads/writes, ALU operations and
// display loads, and runs the register clear sweep.
module mips_mode_sequencer
  import mips_mode_sequencer_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int SWW  = 10,
  parameter int SYNC = 2
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             mem_clr,
  input  logic             enter_bar,
  input  logic [SWW-1:0]   sw,
  output logic [7:0]       LEDG,
  mips_mode_sequencer_if.master bus
);

  logic          enter_p, enter_lvl_unused;
  logic          clr_lvl, clr_fall_unused;
  state_t        state;
  clr_phase_t    clr_phase;
  logic [AW-1:0] addr_q, sr1_q, sr2_q, dr_q, clr_cnt;
  alu_op_t       op_q;
  logic          imm_q, out_q, err_q, issued_q;
  logic          rd_vld_p0, rd_vld_p1;

  mips_mode_sequencer_enter_pulse_sync #(.SYNC(SYNC), .RST_VAL(1'b1)) u_enter_sync (
    .clk   (clk_50M),
    .rst   (rst),
    .din   (enter_bar),
    .level (enter_lvl_unused),
    .fall  (enter_p)
  );

  mips_mode_sequencer_enter_pulse_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_clr_sync (
    .clk   (clk_50M),
    .rst   (rst),
    .din   (mem_clr),
    .level (clr_lvl),
    .fall  (clr_fall_unused)
  );

  // Mode state machine with registered bus outputs; clear overrides enter
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state          <= ST_IDLE;
      clr_phase      <= CLR_SWEEP;
      clr_cnt        <= '0;
      addr_q         <= '0;
      sr1_q          <= '0;
      sr2_q          <= '0;
      dr_q           <= '0;
      op_q           <= ALU_ADD;
      imm_q          <= 1'b0;
      out_q          <= 1'b0;
      err_q          <= 1'b0;
      issued_q       <= 1'b0;
      rd_vld_p0      <= 1'b0;
      rd_vld_p1      <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_wdata  <= '0;
      bus.alu_start  <= 1'b0;
      bus.alu_op     <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.disp_load  <= 1'b0;
      bus.disp_value <= '0;
    end else begin
      bus.mem_we    <= 1'b0;
      bus.alu_start <= 1'b0;
      bus.disp_load <= 1'b0;
      // Read stage p0: address registered; p1: memory has produced rdata
      rd_vld_p0     <= 1'b0;
      rd_vld_p1     <= rd_vld_p0;
      if (rd_vld_p1) begin
        bus.disp_value <= bus.mem_rdata;
        bus.disp_load  <= 1'b1;
      end

      if (clr_lvl && state != ST_CLEAR) begin
        state         <= ST_CLEAR;
        clr_phase     <= CLR_SWEEP;
        clr_cnt       <= '0;
        issued_q      <= 1'b0;
        rd_vld_p1     <= 1'b0;
        bus.disp_load <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (enter_p) begin
            if (sw == SWW'(MODE_SAVE)) begin
              state <= ST_SAVE_A;
              err_q <= 1'b0;
            end else if (sw == SWW'(MODE_READ)) begin
              state <= ST_READ_A;
              err_q <= 1'b0;
            end else if (sw == SWW'(MODE_OP)) begin
              state <= ST_OP_W1;
              err_q <= 1'b0;
            end
          end
          ST_SAVE_A: if (enter_p) begin
            addr_q <= sw[AW-1:0];
            state  <= ST_SAVE_D;
          end
          ST_SAVE_D: if (enter_p) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_q;
            bus.mem_wdata <= DW'(sw);
            state         <= ST_IDLE;
          end
          ST_READ_A: if (enter_p) begin
            bus.mem_addr <= sw[AW-1:0];
            rd_vld_p0    <= 1'b1;
            state        <= ST_READ_S;
          end
          ST_READ_S: if (enter_p) state <= ST_IDLE;
          ST_OP_W1: if (enter_p) begin
            sr1_q <= sw[F_SR1_LSB +: AW];
            sr2_q <= sw[F_SR2_LSB +: AW];
            op_q  <= alu_op_t'(sw[F_OP_LSB +: 2]);
            state <= ST_OP_W2;
          end
          ST_OP_W2: if (enter_p) begin
            imm_q <= sw[F_IMM_BIT];
            dr_q  <= sw[F_DR_LSB +: AW];
            out_q <= sw[F_OUT_BIT];
            state <= ST_OP_ARM;
          end
          ST_OP_ARM: if (enter_p) begin
            bus.mem_addr <= sr1_q;
            state        <= ST_FETCH_A;
          end
          ST_FETCH_A: begin
            bus.mem_addr <= sr2_q;
            state        <= ST_FETCH_B;
          end
          ST_FETCH_B: begin
            bus.alu_a <= bus.mem_rdata;
            issued_q  <= 1'b0;
            state     <= ST_EXEC;
          end
          ST_EXEC: begin
            if (!issued_q) begin
              bus.alu_b     <= imm_q ? DW'(sr2_q) : bus.mem_rdata;
              bus.alu_op    <= op_q;
              bus.alu_start <= 1'b1;
              issued_q      <= 1'b1;
            end else if (bus.alu_done) begin
              issued_q <= 1'b0;
              state    <= ST_IDLE;
              if (bus.alu_err) begin
                bus.disp_value <= DW'(ERR_DISP);
                bus.disp_load  <= 1'b1;
                err_q          <= 1'b1;
              end else if (out_q) begin
                bus.disp_value <= bus.alu_result;
                bus.disp_load  <= 1'b1;
              end else begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= dr_q;
                bus.mem_wdata <= bus.alu_result;
              end
            end
          end
          ST_CLEAR: begin
            case (clr_phase)
              CLR_SWEEP: begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= clr_cnt;
                bus.mem_wdata <= '0;
                clr_cnt       <= clr_cnt + 1'b1;
                if (clr_cnt == {AW{1'b1}}) clr_phase <= CLR_SHOW;
              end
              CLR_SHOW: begin
                bus.disp_value <= '0;
                bus.disp_load  <= 1'b1;
                clr_phase      <= CLR_HOLD;
              end
              default: if (!clr_lvl) state <= ST_IDLE;
            endcase
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign LEDG = {1'b0, err_q, mode_leds(state)};

endmodule
